// File: rtl/add20_share_ctrl.sv
`timescale 1ns/1ps
// add20_share_ctrl
// ----------------
// Time-shares one external 20-bit ripple adder (no carry-in) between NREQ
// requesters. Grants are round-robin, and only one operation is in flight at
// a time.
//
// Subtraction a - b takes two passes through the adder:
//   pass 1 (NEG): ~b + 1 -> b register
//   pass 2 (SUM): a + b  -> result
// Addition uses the SUM pass only.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   req_valid   [NREQ]    requester i has an operation pending
//   req_ready   [NREQ]    one-hot grant, one cycle wide, only in IDLE
//   req_a       [NREQ*W]  operand a, requester i at [i*W +: W]
//   req_b       [NREQ*W]  operand b, same packing
//   req_sub     [NREQ]    1 = a - b, 0 = a + b
//   resp_valid            result available (RESP state)
//   resp_ready            consumer accepts result
//   resp_id     [IDW]     requester that owns the result
//   resp_sum    [W]       result modulo 2^20
//   resp_cout             raw carry-out of the final adder pass
//   add_a/add_b [W]       operands driven to the shared adder
//   add_sum     [W]       adder sum (combinational from add_a/add_b)
//   add_cout              adder carry-out
//   busy                  high in any state other than IDLE
module add20_share_ctrl #(
    parameter int NREQ = 4,
    parameter int W    = 20,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ-1:0]     req_sub,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [W-1:0]        resp_sum,
    output logic                resp_cout,
    output logic [W-1:0]        add_a,
    output logic [W-1:0]        add_b,
    input  logic [W-1:0]        add_sum,
    input  logic                add_cout,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        NEG,
        SUM,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_next;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [IDW-1:0]  id_q;

    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic            grant_take;
    logic [IDW:0]    cand_w;
    logic [IDW-1:0]  cand;
    logic [IDW:0]    ptr_inc;

    // Round-robin search: candidates ptr, ptr+1, ... wrapped modulo NREQ.
    // The first one with req_valid set wins. One extra bit on cand_w keeps
    // ptr+k from overflowing before the wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_w      = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_w = {1'b0, ptr} + (IDW+1)'(k);
            if (cand_w >= (IDW+1)'(NREQ)) begin
                cand_w = cand_w - (IDW+1)'(NREQ);
            end
            cand = cand_w[IDW-1:0];
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // The pointer moves to the requester just after the one granted.
    // grant_id < NREQ, so the only wrap case is grant_id + 1 == NREQ.
    always_comb begin
        ptr_inc  = {1'b0, grant_id} + (IDW+1)'(1);
        ptr_next = ptr_inc[IDW-1:0];
        if (ptr_inc == (IDW+1)'(NREQ)) begin
            ptr_next = '0;
        end
    end

    // A grant is blocked while rst is high, so no req_ready pulse appears
    // during a reset cycle.
    assign grant_take = (state == IDLE) && grant_found && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the per-state drive of the grant and adder operands.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        add_a      = '0;
        add_b      = '0;
        resp_valid = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_take) begin
                    req_ready[grant_id] = 1'b1;
                    state_next = req_sub[grant_id] ? NEG : SUM;
                end
            end
            NEG: begin
                add_a      = ~b_q;
                add_b      = W'(1);
                state_next = SUM;
            end
            SUM: begin
                add_a      = a_q;
                add_b      = b_q;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture on the grant edge, two's-complement negation of b in
    // NEG, and result capture in SUM. The NEG carry-out is dropped: it only
    // comes out 1 for b == 0, where ~0 + 1 wraps to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            resp_sum  <= '0;
            resp_cout <= 1'b0;
            resp_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_take) begin
                        a_q  <= req_a[grant_id*W +: W];
                        b_q  <= req_b[grant_id*W +: W];
                        id_q <= grant_id;
                        ptr  <= ptr_next;
                    end
                end
                NEG: begin
                    b_q <= add_sum;
                end
                SUM: begin
                    resp_sum  <= add_sum;
                    resp_cout <= add_cout;
                    resp_id   <= id_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add20_share_ctrl.sv
`timescale 1ns/1ps
// tb_add20_share_ctrl
// -------------------
// Self-checking bench for add20_share_ctrl. The bench contains a plain
// behavioural model of the shared add20 adder. Expected results come from
// ordinary modular arithmetic on a and b.
module tb_add20_share_ctrl;

    localparam int NREQ = 4;
    localparam int W    = 20;
    localparam int IDW  = 2;
    localparam longint unsigned MOD = 64'd1 << W;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ-1:0]     req_sub;
    logic                resp_valid;
    logic                resp_ready;
    logic [IDW-1:0]      resp_id;
    logic [W-1:0]        resp_sum;
    logic                resp_cout;
    logic [W-1:0]        add_a;
    logic [W-1:0]        add_b;
    logic [W-1:0]        add_sum;
    logic                add_cout;
    logic                busy;

    int checks = 0;
    int errors = 0;

    add20_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .busy       (busy)
    );

    // External add20: 20-bit adder, carry-in tied to 0.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result: a + b modulo 2^20 with a carry out of 2^20. For a
    // subtraction, the carry means a >= b. The exception is b == 0, which
    // gives a and no carry.
    function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic sub,
                                     output logic [W-1:0] s, output logic c);
        longint unsigned ai;
        longint unsigned bi;
        longint unsigned r;
        ai = longint'(a);
        bi = longint'(b);
        if (!sub) begin
            r = ai + bi;
            s = W'(r % MOD);
            c = (r >= MOD);
        end else if (bi == 0) begin
            s = a;
            c = 1'b0;
        end else begin
            r = ai + MOD - bi;
            s = W'(r % MOD);
            c = (ai >= bi);
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic sub);
        req_valid               = '0;
        req_valid[id]           = 1'b1;
        req_a[id*W +: W]        = a;
        req_b[id*W +: W]        = b;
        req_sub[id]             = sub;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one operation from grant through accept, checking the grant, the
    // adder operands, the latency, the result, and behaviour under
    // backpressure. stall = number of extra cycles resp_ready stays low.
    task automatic doOp(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input int stall);
        logic [W-1:0]    expSum;
        logic            expCout;
        logic [W-1:0]    negB;
        logic [NREQ-1:0] oneHot;
        int              lat;
        int              other;
        refModel(a, b, sub, expSum, expCout);
        negB        = ~b;
        oneHot      = '0;
        oneHot[id]  = 1'b1;
        other       = (id + 1) % NREQ;

        @(negedge clk);
        applyStimulus(id, a, b, sub);
        #1;
        checkOutput("grant", 32'(req_ready), 32'(oneHot));
        checkOutput("idle_busy", 32'(busy), 0);

        @(negedge clk);
        req_valid[id]    = 1'b0;
        req_a[id*W +: W] = W'($urandom);
        req_b[id*W +: W] = W'($urandom);
        req_sub[id]      = ~sub;
        lat = 1;
        checkOutput("op_busy", 32'(busy), 1);
        checkOutput("op_no_grant", 32'(req_ready), 0);
        if (sub) begin
            checkOutput("neg_add_a", 32'(add_a), 32'(negB));
            checkOutput("neg_add_b", 32'(add_b), 1);
        end else begin
            checkOutput("sum_add_a", 32'(add_a), 32'(a));
            checkOutput("sum_add_b", 32'(add_b), 32'(b));
        end

        while (resp_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), sub ? 32'd3 : 32'd2);
        checkOutput("resp_sum", 32'(resp_sum), 32'(expSum));
        checkOutput("resp_cout", 32'(resp_cout), 32'(expCout));
        checkOutput("resp_id", 32'(resp_id), 32'(id));
        checkOutput("resp_add_a", 32'(add_a), 0);

        if (stall > 0) begin
            req_valid[other] = 1'b1;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(resp_valid), 1);
            checkOutput("hold_sum", 32'(resp_sum), 32'(expSum));
            checkOutput("hold_cout", 32'(resp_cout), 32'(expCout));
            checkOutput("hold_no_grant", 32'(req_ready), 0);
            checkOutput("hold_busy", 32'(busy), 1);
        end

        resp_ready = 1'b1;
        #1;
        checkOutput("accept_no_grant", 32'(req_ready), 0);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = '0;
        #1;
        checkOutput("after_valid", 32'(resp_valid), 0);
        checkOutput("after_busy", 32'(busy), 0);
    endtask

    int               grantCount;
    int               respCount;
    int               lastGrant;
    int               cyc;
    int               qid [$];
    logic [W-1:0]     rrA [NREQ];
    logic [W-1:0]     rrB [NREQ];
    logic [W-1:0]     expSum;
    logic             expCout;
    logic [NREQ-1:0]  oneHot;
    int               g;
    logic [W-1:0]     ra;
    logic [W-1:0]     rb;

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_sub    = '0;
        resp_ready = 1'b0;

        // After reset, every output is 0.
        resetDut();
        #1;
        checkOutput("rst_resp_valid", 32'(resp_valid), 0);
        checkOutput("rst_resp_id", 32'(resp_id), 0);
        checkOutput("rst_resp_sum", 32'(resp_sum), 0);
        checkOutput("rst_resp_cout", 32'(resp_cout), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_req_ready", 32'(req_ready), 0);
        checkOutput("rst_add_a", 32'(add_a), 0);
        checkOutput("rst_add_b", 32'(add_b), 0);

        // Directed arithmetic cases, including overflow and subtracting zero.
        doOp(0, 20'h00010, 20'h00020, 1'b0, 0);
        doOp(2, 20'h00050, 20'h00020, 1'b1, 0);
        doOp(2, 20'h00010, 20'h00020, 1'b1, 0);
        doOp(1, 20'hFFFFF, 20'h00001, 1'b0, 0);
        doOp(3, 20'h12345, 20'h00000, 1'b1, 0);
        doOp(0, 20'h00000, 20'h00000, 1'b1, 0);
        doOp(3, 20'h00777, 20'h00777, 1'b1, 0);

        // Backpressure: resp_ready low for 5 cycles while another requester waits.
        doOp(1, 20'h0ABCD, 20'h01234, 1'b1, 5);

        // Reset in the NEG pass of a subtraction drops the operation.
        @(negedge clk);
        applyStimulus(2, 20'h00050, 20'h00020, 1'b1);
        #1;
        checkOutput("mid_grant", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = '0;
        checkOutput("mid_neg_add_a", 32'(add_a), 32'hFFFDF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_busy", 32'(busy), 0);
        checkOutput("mid_resp_valid", 32'(resp_valid), 0);
        checkOutput("mid_resp_sum", 32'(resp_sum), 0);
        checkOutput("mid_add_a", 32'(add_a), 0);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checkOutput("mid_no_resp", 32'(resp_valid), 0);
        end
        // If ptr is back at 0, requester 1 wins over 3. Without the reset, ptr
        // would be 3 and requester 3 would win.
        req_valid = 4'b1010;
        #1;
        checkOutput("mid_ptr_zero", 32'(req_ready), 32'h2);
        req_valid = '0;
        doOp(1, 20'h00100, 20'h00200, 1'b0, 0);

        // All requesters held valid with resp_ready high: grants follow
        // 0,1,2,3,0 with one grant every 3 cycles.
        resetDut();
        for (int i = 0; i < NREQ; i++) begin
            rrA[i] = W'($urandom);
            rrB[i] = W'($urandom);
            req_a[i*W +: W] = rrA[i];
            req_b[i*W +: W] = rrB[i];
        end
        req_sub    = '0;
        req_valid  = '1;
        resp_ready = 1'b1;
        grantCount = 0;
        respCount  = 0;
        lastGrant  = 0;
        cyc        = 0;
        #1;
        while (respCount < 5 && cyc < 80) begin
            if (req_ready !== '0) begin
                oneHot = '0;
                oneHot[grantCount % NREQ] = 1'b1;
                checkOutput("rr_grant", 32'(req_ready), 32'(oneHot));
                checkOutput("rr_idle", 32'(busy), 0);
                if (grantCount > 0) begin
                    checkOutput("rr_spacing", 32'(cyc - lastGrant), 3);
                end
                qid.push_back(grantCount % NREQ);
                lastGrant = cyc;
                grantCount++;
            end
            if (resp_valid === 1'b1) begin
                if (qid.size() > 0) begin
                    g = qid.pop_front();
                    refModel(rrA[g], rrB[g], 1'b0, expSum, expCout);
                    checkOutput("rr_resp_id", 32'(resp_id), 32'(g));
                    checkOutput("rr_resp_sum", 32'(resp_sum), 32'(expSum));
                    checkOutput("rr_resp_cout", 32'(resp_cout), 32'(expCout));
                end else begin
                    checkOutput("rr_resp_without_grant", 32'(resp_valid), 0);
                end
                respCount++;
            end
            @(negedge clk);
            #1;
            cyc++;
        end
        checkOutput("rr_resp_count", 32'(respCount), 5);
        req_valid  = '0;
        resp_ready = 1'b0;
        resetDut();

        // Randomized single operations, weighted toward b = 0 and the
        // extreme operand values.
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = '1;
                2: rb = '1;
                3: rb = ra;
                default: begin
                end
            endcase
            doOp(int'($urandom_range(0, NREQ-1)), ra, rb, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
